simon_key_reverse_shiftreg: RTL and testbench

SIMON_KEY_REVERSE_SHIFTREG -- requirements
Module: simon_key_reverse_shiftreg

---
 rtl/simon_pkg.sv | 32 +++
 rtl/simon_key_reverse_shiftreg_if.sv | 28 ++
 rtl/simon_wrap_buf.sv | 23 ++
 rtl/simon_key_reverse_shiftreg.sv | 109 ++++++++++
 tb/tb_simon_key_reverse_shiftreg.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared Simon128/128 constants and helpers for the forward and reverse key schedules.
package simon_pkg;

    localparam int unsigned WordWidth = 64;
    localparam int unsigned KeyLength = 128;
    localparam int unsigned NumRounds = 68;

    // z2 sequence, 68 bits, Z[0] is the MSB (bit 67).
    localparam logic [67:0] ZConst = 68'hAF703498A11F96CEB;

    // Last decryption round that still consumes a real Z bit (Z[65-r] with r <= 65).
    localparam logic [6:0] LastZtRound = 7'd65;

    // Meaning of the two-bit data_rdy control.
    typedef enum logic [1:0] {
        RdyIdle = 2'd0,
        RdyHold = 2'd1,
        RdyLoad = 2'd2,
        RdyRun  = 2'd3
    } rdy_mode_e;

    // Z[idx] with MSB-first indexing; idx must be 0..67.
    function automatic logic z_bit(input logic [6:0] idx);
        return ZConst[7'd67 - idx];
    endfunction

    // Bit j of the round constant c = 2^64 - 4.
    function automatic logic const_bit(input logic [5:0] j);
        return (j > 6'd1);
    endfunction

endpackage

// File: rtl/simon_key_reverse_shiftreg_if.sv
// Serial control/data bundle between the datapath controller and the reverse key schedule.
interface simon_key_reverse_shiftreg_if;

    logic       data_in;
    logic [1:0] data_rdy;
    logic [5:0] bit_counter;
    logic       key_out;
    logic [6:0] round_counter;

    // Controller side: drives mode, bit index and serial load data.
    modport master (
        output data_in,
        output data_rdy,
        output bit_counter,
        input  key_out,
        input  round_counter
    );

    // Key schedule side.
    modport slave (
        input  data_in,
        input  data_rdy,
        input  bit_counter,
        output key_out,
        output round_counter
    );

endinterface

// File: rtl/simon_wrap_buf.sv
// 4-bit capture shift buffer: holds nxt bits 0..3 after they leave the serial chain.
module simon_wrap_buf (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       din,
    output logic [3:0] dout
);

    logic [3:0] buf_q;

    // Shift in at the top so that after four captures dout[i] holds original bit i.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= 4'b0;
        end else if (en) begin
            buf_q <= {din, buf_q[3:1]};
        end
    end

    assign dout = buf_q;

endmodule

// File: rtl/simon_key_reverse_shiftreg.sv
// Bit-serial Simon128/128 reverse key schedule: emits k[67], k[66], ... k[0], LSB first.
module simon_key_reverse_shiftreg
    import simon_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    simon_key_reverse_shiftreg_if.slave  bus
);

    logic [WordWidth-1:0] cur_q, cur_d;
    logic [WordWidth-1:0] nxt_q, nxt_d;
    logic [6:0]           round_q, round_d;
    logic [3:0]           wrap;
    logic                 wrap_en;
    rdy_mode_e            mode;
    logic                 la3, la4;
    logic                 zt;
    logic                 run_bit;

    assign mode = rdy_mode_e'(bus.data_rdy);

    // Original nxt bits 0..3 pass nxt[0] during run cycles 0..3; keep them for the word tail.
    assign wrap_en = (mode == RdyRun) && (bus.bit_counter < 6'd4);

    simon_wrap_buf u_wrap_buf (
        .clk   (clk),
        .reset (reset),
        .en    (wrap_en),
        .din   (nxt_q[0]),
        .dout  (wrap)
    );

    // Select original nxt[(j+3)%64] and nxt[(j+4)%64]; near the word end they come from wrap.
    always_comb begin
        la3 = nxt_q[3];
        la4 = nxt_q[4];
        unique case (bus.bit_counter)
            6'd60: begin
                la4 = wrap[0];
            end
            6'd61: begin
                la3 = wrap[0];
                la4 = wrap[1];
            end
            6'd62: begin
                la3 = wrap[1];
                la4 = wrap[2];
            end
            6'd63: begin
                la3 = wrap[2];
                la4 = wrap[3];
            end
            default: ;
        endcase
    end

    // Z term enters only at bit 0; the last two rounds compute a don't-care word with zt = 0.
    always_comb begin
        zt = 1'b0;
        if ((bus.bit_counter == 6'd0) && (round_q <= LastZtRound)) begin
            zt = z_bit(LastZtRound - round_q);
        end
    end

    // k[i] = k[i+2] ^ ror(k[i+1],3) ^ ror(k[i+1],4) ^ c ^ z[i], one bit per cycle.
    assign run_bit = cur_q[0] ^ la3 ^ la4 ^ const_bit(bus.bit_counter) ^ zt;

    // Next-state: shift the nxt->cur chain in load/run, hold otherwise; idle clears the round.
    always_comb begin
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        round_d = round_q;
        unique case (mode)
            RdyIdle: begin
                round_d = 7'd0;
            end
            RdyHold: ;
            RdyLoad: begin
                nxt_d = {bus.data_in, nxt_q[WordWidth-1:1]};
                cur_d = {nxt_q[0], cur_q[WordWidth-1:1]};
            end
            RdyRun: begin
                nxt_d = {run_bit, nxt_q[WordWidth-1:1]};
                cur_d = {nxt_q[0], cur_q[WordWidth-1:1]};
                if (bus.bit_counter == 6'd63) begin
                    round_d = round_q + 7'd1;
                end
            end
            default: ;
        endcase
    end

    // State registers with synchronous reset taking priority over data_rdy.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q   <= '0;
            nxt_q   <= '0;
            round_q <= 7'd0;
        end else begin
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            round_q <= round_d;
        end
    end

    assign bus.key_out       = cur_q[0];
    assign bus.round_counter = round_q;

endmodule

// File: tb/tb_simon_key_reverse_shiftreg.sv
// Self-checking bench for simon_key_reverse_shiftreg against a word-level forward key expansion.
module tb_simon_key_reverse_shiftreg;

    localparam logic [63:0] CWord = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    simon_key_reverse_shiftreg_if bus_if ();

    simon_key_reverse_shiftreg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int errors = 0;
    int checks = 0;

    string z2_str = "10101111011100000011010010011000101000010001111110010110110011";

    logic [63:0] fk [68];
    logic [63:0] got [68];
    logic [6:0]  rc_at0 [68];
    logic [6:0]  rc_at63 [68];

    typedef struct {
        logic [63:0] k67;
        logic [63:0] k66;
        int          round;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [6];

    function automatic logic zseq(input int i);
        return z2_str[i % 62] == "1";
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    task automatic expand(input logic [127:0] key);
        fk[0] = key[63:0];
        fk[1] = key[127:64];
        for (int i = 0; i < 66; i++) begin
            fk[i+2] = CWord ^ {63'b0, zseq(i)} ^ fk[i] ^ ror(fk[i+1], 3) ^ ror(fk[i+1], 4);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_words(input logic [63:0] k67, input logic [63:0] k66);
        bus_if.data_rdy = 2'd2;
        for (int i = 0; i < 128; i++) begin
            bus_if.data_in     = (i < 64) ? k67[i] : k66[i-64];
            bus_if.bit_counter = 6'(i % 64);
            tick();
        end
        bus_if.data_rdy = 2'd0;
        bus_if.data_in  = 1'b0;
        tick();
    endtask

    // Runs 68 rounds; optional 5-cycle hold at (pr,pb); optional reset at (rr,rb) aborts the run.
    task automatic run_rounds(input int pr, input int pb, input int rr, input int rb);
        logic [6:0] rc;
        for (int r = 0; r < 68; r++) begin
            for (int j = 0; j < 64; j++) begin
                if (r == rr && j == rb) begin
                    bus_if.data_rdy    = 2'd3;
                    bus_if.bit_counter = 6'(j);
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    bus_if.data_rdy = 2'd1;
                    @(negedge clk);
                    check("reset_round_counter", {57'b0, bus_if.round_counter}, 64'd0);
                    check("reset_key_out", {63'b0, bus_if.key_out}, 64'd0);
                    tick();
                    return;
                end
                if (r == pr && j == pb) begin
                    bus_if.data_rdy    = 2'd1;
                    bus_if.bit_counter = 6'(j);
                    repeat (5) begin
                        bus_if.data_in = 1'($urandom_range(0, 1));
                        tick();
                    end
                end
                bus_if.data_rdy    = 2'd3;
                bus_if.bit_counter = 6'(j);
                bus_if.data_in     = 1'($urandom_range(0, 1));
                @(negedge clk);
                got[r][j] = bus_if.key_out;
                rc = bus_if.round_counter;
                if (j == 0) rc_at0[r] = rc;
                if (j == 63) rc_at63[r] = rc;
                tick();
            end
        end
        bus_if.data_rdy = 2'd1;
    endtask

    task automatic compare_run(input string name);
        for (int r = 0; r < 68; r++) begin
            check($sformatf("%s_word_r%0d", name, r), got[r], fk[67-r]);
            check($sformatf("%s_rc0_r%0d", name, r), {57'b0, rc_at0[r]}, 64'(r));
            check($sformatf("%s_rc63_r%0d", name, r), {57'b0, rc_at63[r]}, 64'(r));
        end
    endtask

    initial begin
        logic [127:0] spec_key;
        logic [127:0] key;
        logic [127:0] loaded;
        logic         have_loaded;
        logic [63:0]  km1, km2, tail;

        spec_key = 128'h0f0e0d0c0b0a0908_0706050403020100;

        reset              = 1'b1;
        bus_if.data_in     = 1'b0;
        bus_if.data_rdy    = 2'd0;
        bus_if.bit_counter = 6'd0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_state_key_out", {63'b0, bus_if.key_out}, 64'd0);
        check("reset_state_round", {57'b0, bus_if.round_counter}, 64'd0);
        tick();
        reset = 1'b0;

        // Spot-check table: zero words and the reference key's final two rounds.
        expand(spec_key);
        vecs[0] = '{k67: 64'd0, k66: 64'd0, round: 0, exp: 64'd0};
        vecs[1] = '{k67: 64'd0, k66: 64'd0, round: 1, exp: 64'd0};
        vecs[2] = '{k67: 64'd0, k66: 64'd0, round: 2, exp: 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[3] = '{k67: fk[67], k66: fk[66], round: 66, exp: 64'h0f0e0d0c0b0a0908};
        vecs[4] = '{k67: fk[67], k66: fk[66], round: 67, exp: 64'h0706050403020100};
        vecs[5] = '{k67: fk[67], k66: fk[66], round: 0, exp: fk[67]};
        have_loaded = 1'b0;
        loaded      = '0;
        for (int i = 0; i < 6; i++) begin
            if (!have_loaded || loaded !== {vecs[i].k67, vecs[i].k66}) begin
                load_words(vecs[i].k67, vecs[i].k66);
                run_rounds(-1, -1, -1, -1);
                loaded      = {vecs[i].k67, vecs[i].k66};
                have_loaded = 1'b1;
            end
            check($sformatf("vec%0d_round%0d", i, vecs[i].round), got[vecs[i].round], vecs[i].exp);
        end

        // Full-sequence cross-check for the reference key and random keys.
        for (int t = 0; t < 4; t++) begin
            key = (t == 0) ? spec_key : {$urandom, $urandom, $urandom, $urandom};
            expand(key);
            load_words(fk[67], fk[66]);
            run_rounds(-1, -1, -1, -1);
            compare_run($sformatf("key%0d", t));
        end

        // After round 67: round_counter = 68, idle clears it while cur/nxt hold.
        expand(spec_key);
        load_words(fk[67], fk[66]);
        run_rounds(-1, -1, -1, -1);
        km1 = fk[1] ^ ror(fk[0], 3) ^ ror(fk[0], 4) ^ CWord;
        km2 = fk[0] ^ ror(km1, 3) ^ ror(km1, 4) ^ CWord;
        @(negedge clk);
        check("end_round_counter", {57'b0, bus_if.round_counter}, 64'd68);
        check("end_key_out", {63'b0, bus_if.key_out}, {63'b0, km1[0]});
        tick();
        bus_if.data_rdy = 2'd0;
        tick();
        bus_if.data_rdy = 2'd1;
        @(negedge clk);
        check("idle_round_counter", {57'b0, bus_if.round_counter}, 64'd0);
        tick();
        // The held cur word is k[-1]; the word after it is the held nxt, k[-2].
        for (int w = 0; w < 2; w++) begin
            for (int j = 0; j < 64; j++) begin
                bus_if.data_rdy    = 2'd3;
                bus_if.bit_counter = 6'(j);
                @(negedge clk);
                tail[j] = bus_if.key_out;
                tick();
            end
            check($sformatf("held_word%0d", w), tail, (w == 0) ? km1 : km2);
        end
        bus_if.data_rdy = 2'd1;

        // Hold for 5 cycles mid-word must not disturb the sequence.
        expand(spec_key);
        load_words(fk[67], fk[66]);
        run_rounds(10, 37, -1, -1);
        compare_run("pause");

        // Reset mid-run aborts; a reload reproduces the reference sequence.
        load_words(fk[67], fk[66]);
        run_rounds(-1, -1, 20, 50);
        load_words(fk[67], fk[66]);
        run_rounds(-1, -1, -1, -1);
        compare_run("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
